// File: rtl/uart_loader_ctrl_if.sv
// uart_loader_ctrl_if
// Bundles the UART receive/transmit handshakes and the instruction-memory
// write port of the serial program loader.
//   master : loader side (drives clear/transmit/memory/run/full)
//   slave  : UART + memory side (drives rx_rdy, rx_data, tx_busy)
// Signals:
//   rx_rdy, rx_data       received-byte flag and byte
//   rx_rdy_clr            one-cycle clear of the receive flag
//   tx_busy               transmitter busy
//   tx_din, tx_wr_en      byte to send and its one-cycle strobe
//   mem_we, mem_addr,
//   mem_wdata             one-cycle instruction-memory write
//   run, full             core release level, memory-full level
interface uart_loader_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              rx_rdy_clr;
    logic              tx_busy;
    logic [7:0]        tx_din;
    logic              tx_wr_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              run;
    logic              full;

    modport master (
        input  rx_rdy, rx_data, tx_busy,
        output rx_rdy_clr, tx_din, tx_wr_en, mem_we, mem_addr, mem_wdata, run, full
    );

    modport slave (
        output rx_rdy, rx_data, tx_busy,
        input  rx_rdy_clr, tx_din, tx_wr_en, mem_we, mem_addr, mem_wdata, run, full
    );
endinterface

// File: rtl/uart_loader_ctrl.sv
// uart_loader_ctrl
// Serial program loader. Takes ASCII hex from the host, packs 8 nibbles
// (MSB first) into a 32-bit word and writes each word to instruction memory
// at an auto-incrementing address. Accepted hex digits are echoed (ECHO=1),
// each word/command is answered with a one-byte status, and 'G' releases
// the core via run.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  uart_loader_ctrl_if.master (UART rx/tx handshakes, memory write,
//        run and full levels)
module uart_loader_ctrl #(
    parameter int ADDR_W = 4,
    parameter bit ECHO   = 1'b1
) (
    input logic               clk,
    input logic               rst,
    uart_loader_ctrl_if.master bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] SEND   = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;

    localparam logic [7:0] ST_OK   = 8'h4B;
    localparam logic [7:0] ST_FULL = 8'h21;
    localparam logic [7:0] ST_ZAP  = 8'h5A;
    localparam logic [7:0] ST_GO   = 8'h47;
    localparam logic [7:0] ST_BAD  = 8'h3F;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ||
               (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Letters 'A'/'a' have low nibble 1, so adding 9 maps them to 10..15.
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

    logic [2:0]        state;
    logic [7:0]        byte_q;
    logic [31:0]       word;
    logic [2:0]        ncnt;
    logic [ADDR_W-1:0] addr;
    logic              full;
    logic              run;
    logic              pend;
    logic [7:0]        pend_byte;
    logic [7:0]        tx_din;
    logic              tx_wr_en;
    logic              rx_rdy_clr;
    logic              mem_we;

    logic       hex;
    logic       last;
    logic       is_zap;
    logic       is_go;
    logic       is_eol;
    logic       status_vld;
    logic [7:0] status_byte;
    logic       first_vld;
    logic [7:0] first_byte;
    logic       second_vld;
    logic [7:0] second_byte;

    // Classify the latched byte and build the transmit queue: echo first,
    // status second. When there is no echo the status goes out first.
    always_comb begin
        hex         = is_hex(byte_q);
        last        = hex && (ncnt == 3'd7);
        is_zap      = (byte_q == 8'h5A) || (byte_q == 8'h7A);
        is_go       = (byte_q == 8'h47) || (byte_q == 8'h67);
        is_eol      = (byte_q == 8'h0D) || (byte_q == 8'h0A);
        status_vld  = 1'b0;
        status_byte = ST_BAD;
        if (hex) begin
            status_vld  = last;
            status_byte = full ? ST_FULL : ST_OK;
        end else if (is_zap) begin
            status_vld  = 1'b1;
            status_byte = ST_ZAP;
        end else if (is_go) begin
            status_vld  = 1'b1;
            status_byte = ST_GO;
        end else if (!is_eol) begin
            status_vld  = 1'b1;
            status_byte = ST_BAD;
        end
        if (hex && ECHO) begin
            first_vld   = 1'b1;
            first_byte  = byte_q;
            second_vld  = status_vld;
            second_byte = status_byte;
        end else begin
            first_vld   = status_vld;
            first_byte  = status_byte;
            second_vld  = 1'b0;
            second_byte = status_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_q     <= 8'h00;
            word       <= 32'h0;
            ncnt       <= 3'd0;
            addr       <= '0;
            full       <= 1'b0;
            run        <= 1'b0;
            pend       <= 1'b0;
            pend_byte  <= 8'h00;
            tx_din     <= 8'h00;
            tx_wr_en   <= 1'b0;
            rx_rdy_clr <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            rx_rdy_clr <= 1'b0;
            tx_wr_en   <= 1'b0;
            mem_we     <= 1'b0;
            // Address advances the cycle after the write strobe; writing the
            // top address marks the memory full and wraps the counter.
            if (mem_we) begin
                addr <= addr + 1'b1;
                if (addr == '1)
                    full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.rx_rdy && !bus.tx_busy) begin
                        rx_rdy_clr <= 1'b1;
                        byte_q     <= bus.rx_data;
                        state      <= DECODE;
                    end
                end
                DECODE: begin
                    if (hex) begin
                        word <= {word[27:0], hex_val(byte_q)};
                        if (last) begin
                            ncnt   <= 3'd0;
                            mem_we <= !full;
                        end else begin
                            ncnt <= ncnt + 3'd1;
                        end
                    end else if (is_zap) begin
                        word <= 32'h0;
                        ncnt <= 3'd0;
                        addr <= '0;
                        full <= 1'b0;
                        run  <= 1'b0;
                    end else if (is_go) begin
                        run <= 1'b1;
                    end
                    if (first_vld) begin
                        tx_wr_en  <= 1'b1;
                        tx_din    <= first_byte;
                        pend      <= second_vld;
                        pend_byte <= second_byte;
                        state     <= SEND;
                    end else begin
                        pend  <= 1'b0;
                        state <= HOLD;
                    end
                end
                SEND: state <= HOLD;
                // One cycle in which tx_busy has not yet risen after a strobe.
                HOLD: state <= WAIT;
                WAIT: begin
                    if (!bus.tx_busy) begin
                        if (pend) begin
                            tx_wr_en <= 1'b1;
                            tx_din   <= pend_byte;
                            pend     <= 1'b0;
                            state    <= SEND;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_rdy_clr = rx_rdy_clr;
    assign bus.tx_din     = tx_din;
    assign bus.tx_wr_en   = tx_wr_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = addr;
    assign bus.mem_wdata  = word;
    assign bus.run        = run;
    assign bus.full       = full;

endmodule
